// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe game controller: square encodings,
// FSM state encoding, move limit and small board-access helpers.
package ttt_pkg;

   localparam int unsigned NUM_SQ  = 9;
   localparam int unsigned BOARD_W = 2 * NUM_SQ;

   // Two-bit square encodings; 2'b11 is never written.
   localparam logic [1:0] SQ_EMPTY = 2'b00;
   localparam logic [1:0] SQ_P1    = 2'b01;
   localparam logic [1:0] SQ_P2    = 2'b10;

   localparam logic [3:0] MAX_MOVES = 4'd9;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StTurn  = 2'd1,
      StCheck = 2'd2,
      StDone  = 2'd3
   } state_e;

   // Square code written for the player to move (0 -> P1, 1 -> P2).
   function automatic logic [1:0] player_code(input logic player);
      return player ? SQ_P2 : SQ_P1;
   endfunction

   // Read square idx (0-based) from a packed board.
   function automatic logic [1:0] sq_get(input logic [BOARD_W-1:0] b, input int unsigned idx);
      logic [BOARD_W-1:0] sh;
      sh = b >> (2 * idx);
      return sh[1:0];
   endfunction

endpackage

// File: rtl/ttt_line_detect.sv
// Purely combinational win detector: flags any row, column or diagonal fully
// owned by player 1 or player 2.
module ttt_line_detect
   import ttt_pkg::*;
(
   input  logic [BOARD_W-1:0] board,
   output logic               p1_line,
   output logic               p2_line
);

   // True when squares a, b, c (0-based) all hold code.
   function automatic logic line_of(input logic [BOARD_W-1:0] brd, input logic [1:0] code,
                                    input int unsigned a, input int unsigned b,
                                    input int unsigned c);
      return (sq_get(brd, a) == code) && (sq_get(brd, b) == code) && (sq_get(brd, c) == code);
   endfunction

   // True when any of the eight lines is fully owned by code.
   function automatic logic any_line(input logic [BOARD_W-1:0] brd, input logic [1:0] code);
      return line_of(brd, code, 0, 1, 2) | line_of(brd, code, 3, 4, 5) |
             line_of(brd, code, 6, 7, 8) | line_of(brd, code, 0, 3, 6) |
             line_of(brd, code, 1, 4, 7) | line_of(brd, code, 2, 5, 8) |
             line_of(brd, code, 0, 4, 8) | line_of(brd, code, 2, 4, 6);
   endfunction

   // Evaluate both players against all eight lines.
   always_comb begin
      p1_line = any_line(board, SQ_P1);
      p2_line = any_line(board, SQ_P2);
   end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: accepts alternating moves, evaluates the board
// one cycle after each accepted move and reports win / draw. Every output is
// driven straight from a register.
module ttt_game_ctrl
   import ttt_pkg::*;
(
   input  logic               clk,
   input  logic               clr,
   input  logic               start,
   input  logic               move_valid,
   input  logic [3:0]         move_sq,
   output logic [BOARD_W-1:0] board,
   output logic               cur_player,
   output logic               move_ack,
   output logic               move_rej,
   output logic               player_win,
   output logic               player_1_win,
   output logic               player_2_win,
   output logic               draw,
   output logic               game_over
);

   state_e             state_q, state_d;
   logic [BOARD_W-1:0] board_q, board_d;
   logic [3:0]         count_q, count_d;
   logic               cur_player_q, cur_player_d;
   logic               ack_q, ack_d;
   logic               rej_q, rej_d;
   logic               win_q, win_d;
   logic               p1_win_q, p1_win_d;
   logic               p2_win_q, p2_win_d;
   logic               draw_q, draw_d;
   logic               over_q, over_d;

   logic               p1_line, p2_line;
   logic               sq_in_range;
   logic               target_empty;
   logic               move_legal;
   logic               mover_win;

   ttt_line_detect u_line_detect (
      .board   (board_q),
      .p1_line (p1_line),
      .p2_line (p2_line)
   );

   // Decode the requested square and the current mover's win status.
   always_comb begin
      sq_in_range  = (move_sq >= 4'd1) && (move_sq <= 4'd9);
      target_empty = 1'b0;
      for (int k = 0; k < NUM_SQ; k++) begin
         if (move_sq == 4'(k + 1)) begin
            target_empty = (sq_get(board_q, k) == SQ_EMPTY);
         end
      end
      move_legal = sq_in_range && target_empty;
      // Only the player who just moved can have completed a line.
      mover_win  = cur_player_q ? p2_line : p1_line;
   end

   // State and registered outputs; clr dominates everything.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q      <= StIdle;
         board_q      <= '0;
         count_q      <= '0;
         cur_player_q <= 1'b0;
         ack_q        <= 1'b0;
         rej_q        <= 1'b0;
         win_q        <= 1'b0;
         p1_win_q     <= 1'b0;
         p2_win_q     <= 1'b0;
         draw_q       <= 1'b0;
         over_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         board_q      <= board_d;
         count_q      <= count_d;
         cur_player_q <= cur_player_d;
         ack_q        <= ack_d;
         rej_q        <= rej_d;
         win_q        <= win_d;
         p1_win_q     <= p1_win_d;
         p2_win_q     <= p2_win_d;
         draw_q       <= draw_d;
         over_q       <= over_d;
      end
   end

   // Next-state logic; start restarts the game from any state.
   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = StTurn;
      end else begin
         case (state_q)
            StIdle:  state_d = StIdle;
            StTurn:  if (move_valid && move_legal) state_d = StCheck;
            StCheck: state_d = (mover_win || (count_q == MAX_MOVES)) ? StDone : StTurn;
            StDone:  state_d = StDone;
            default: state_d = StIdle;
         endcase
      end
   end

   // Next values of board, counters, pulses and result flags.
   always_comb begin
      board_d      = board_q;
      count_d      = count_q;
      cur_player_d = cur_player_q;
      ack_d        = 1'b0;
      rej_d        = 1'b0;
      win_d        = win_q;
      p1_win_d     = p1_win_q;
      p2_win_d     = p2_win_q;
      draw_d       = draw_q;
      over_d       = (state_d == StDone);

      if (start) begin
         // A move presented together with start is discarded silently.
         board_d      = '0;
         count_d      = '0;
         cur_player_d = 1'b0;
         win_d        = 1'b0;
         p1_win_d     = 1'b0;
         p2_win_d     = 1'b0;
         draw_d       = 1'b0;
      end else begin
         case (state_q)
            StTurn: begin
               if (move_valid) begin
                  if (move_legal) begin
                     // Target is known empty, so OR-ing in the code is a write.
                     board_d = board_q | ({{(BOARD_W - 2){1'b0}}, player_code(cur_player_q)}
                                          << {move_sq - 4'd1, 1'b0});
                     count_d = (count_q >= MAX_MOVES) ? MAX_MOVES : count_q + 4'd1;
                     ack_d   = 1'b1;
                  end else begin
                     rej_d = 1'b1;
                  end
               end
            end
            StCheck: begin
               rej_d = move_valid;
               if (mover_win) begin
                  win_d    = 1'b1;
                  p1_win_d = ~cur_player_q;
                  p2_win_d = cur_player_q;
               end else if (count_q == MAX_MOVES) begin
                  draw_d = 1'b1;
               end else begin
                  cur_player_d = ~cur_player_q;
               end
            end
            default: begin
               // Idle and Done: any move request is refused.
               rej_d = move_valid;
            end
         endcase
      end
   end

   assign board        = board_q;
   assign cur_player   = cur_player_q;
   assign move_ack     = ack_q;
   assign move_rej     = rej_q;
   assign player_win   = win_q;
   assign player_1_win = p1_win_q;
   assign player_2_win = p2_win_q;
   assign draw         = draw_q;
   assign game_over    = over_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Self-checking bench for ttt_game_ctrl: directed game scenarios followed by
// randomized play, compared every cycle against a game-level reference model.
module tb_ttt_game_ctrl;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic        start = 1'b0;
   logic        move_valid = 1'b0;
   logic [3:0]  move_sq = 4'd0;
   logic [17:0] board;
   logic        cur_player, move_ack, move_rej;
   logic        player_win, player_1_win, player_2_win, draw, game_over;

   always #5 clk = ~clk;

   ttt_game_ctrl dut (
      .clk          (clk),
      .clr          (clr),
      .start        (start),
      .move_valid   (move_valid),
      .move_sq      (move_sq),
      .board        (board),
      .cur_player   (cur_player),
      .move_ack     (move_ack),
      .move_rej     (move_rej),
      .player_win   (player_win),
      .player_1_win (player_1_win),
      .player_2_win (player_2_win),
      .draw         (draw),
      .game_over    (game_over)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: board as an array of owners (0 none, 1 P1, 2 P2).
   localparam int PhIdle  = 0;
   localparam int PhTurn  = 1;
   localparam int PhCheck = 2;
   localparam int PhDone  = 3;

   int m_brd [9];
   int m_player, m_moves, m_phase;
   bit m_ack, m_rej, m_p1w, m_p2w, m_draw;
   int lines [8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}, '{0, 3, 6},
                        '{1, 4, 7}, '{2, 5, 8}, '{0, 4, 8}, '{2, 4, 6}};

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int winner();
      for (int l = 0; l < 8; l++) begin
         if (m_brd[lines[l][0]] != 0 && m_brd[lines[l][0]] == m_brd[lines[l][1]] &&
             m_brd[lines[l][1]] == m_brd[lines[l][2]]) return m_brd[lines[l][0]];
      end
      return 0;
   endfunction

   function automatic logic [17:0] pack_board();
      int acc = 0;
      for (int k = 0; k < 9; k++) acc += m_brd[k] * (4 ** k);
      return 18'(acc);
   endfunction

   task automatic model_new_game();
      for (int k = 0; k < 9; k++) m_brd[k] = 0;
      m_player = 0;
      m_moves  = 0;
      m_p1w    = 0;
      m_p2w    = 0;
      m_draw   = 0;
   endtask

   task automatic model_step(input bit c, input bit s, input bit mv, input int sq);
      m_ack = 0;
      m_rej = 0;
      if (c) begin
         model_new_game();
         m_phase = PhIdle;
      end else if (s) begin
         model_new_game();
         m_phase = PhTurn;
      end else if (m_phase == PhTurn) begin
         if (mv) begin
            if (sq >= 1 && sq <= 9 && m_brd[sq - 1] == 0) begin
               m_brd[sq - 1] = m_player + 1;
               if (m_moves < 9) m_moves++;
               m_ack   = 1;
               m_phase = PhCheck;
            end else begin
               m_rej = 1;
            end
         end
      end else if (m_phase == PhCheck) begin
         m_rej = mv;
         if (winner() == m_player + 1) begin
            if (m_player == 0) m_p1w = 1;
            else m_p2w = 1;
            m_phase = PhDone;
         end else if (m_moves == 9) begin
            m_draw  = 1;
            m_phase = PhDone;
         end else begin
            m_player = 1 - m_player;
            m_phase  = PhTurn;
         end
      end else begin
         m_rej = mv;
      end
   endtask

   task automatic compare_all();
      logic [7:0] exp_flags;
      exp_flags = {m_player[0], m_ack, m_rej, m_p1w | m_p2w, m_p1w, m_p2w, m_draw,
                   m_phase == PhDone};
      chk_eq("board", 32'(board), 32'(pack_board()));
      chk_eq("flags", 32'({cur_player, move_ack, move_rej, player_win, player_1_win,
                           player_2_win, draw, game_over}), 32'(exp_flags));
      chk_eq("ack_rej_excl", 32'(move_ack & move_rej), 32'd0);
      chk_eq("draw_win_excl", 32'(draw & player_win), 32'd0);
   endtask

   // One clock: drive inputs, advance model at the edge, sample 1 time unit later.
   task automatic cyc(input bit c, input bit s, input bit mv, input int sq);
      clr        = c;
      start      = s;
      move_valid = mv;
      move_sq    = 4'(sq);
      @(posedge clk);
      model_step(c, s, mv, sq);
      #1;
      compare_all();
   endtask

   // Play n moves, leaving an idle cycle for evaluation after each.
   task automatic play(input int sqs [9], input int n);
      for (int i = 0; i < n; i++) begin
         cyc(0, 0, 1, sqs[i]);
         cyc(0, 0, 0, 0);
      end
   endtask

   initial begin
      model_new_game();
      m_phase = PhIdle;
      m_ack   = 0;
      m_rej   = 0;

      // Reset state
      cyc(1, 0, 0, 0);
      chk_eq("reset_all", 32'({board, cur_player, move_ack, move_rej, player_win, player_1_win,
                               player_2_win, draw, game_over}), 32'd0);

      // Row win for player 1 on squares 1,2,3
      cyc(0, 1, 0, 0);
      play('{1, 4, 2, 5, 3, 0, 0, 0, 0}, 5);
      chk_eq("row_win_flags", 32'({player_win, player_1_win, player_2_win, draw, game_over}),
             32'h19);
      chk_eq("row1_bits", 32'(board[5:0]), 32'h15);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
      cyc(0, 0, 1, 7);
      chk_eq("done_rej", 32'(move_rej), 32'd1);

      // Occupied and out-of-range squares
      cyc(0, 1, 0, 0);
      cyc(0, 0, 1, 5);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 1, 5);
      chk_eq("occupied_rej", 32'({move_rej, cur_player}), 32'h3);
      chk_eq("occupied_board", 32'(board), 32'h100);
      cyc(0, 0, 1, 0);
      chk_eq("sq0_rej", 32'(move_rej), 32'd1);
      cyc(0, 0, 1, 10);
      chk_eq("sq10_rej", 32'(move_rej), 32'd1);

      // Draw
      cyc(0, 1, 0, 0);
      play('{1, 2, 3, 5, 4, 6, 8, 7, 9}, 9);
      chk_eq("draw_flags", 32'({player_win, draw, game_over}), 32'h3);
      cyc(0, 0, 1, 1);
      chk_eq("draw_then_rej", 32'(move_rej), 32'd1);

      // Player 1 wins the diagonal on the ninth move
      cyc(0, 1, 0, 0);
      play('{1, 3, 2, 4, 5, 7, 6, 8, 9}, 9);
      chk_eq("ninth_win", 32'({player_1_win, player_2_win, draw, game_over}), 32'h9);

      // start beats a simultaneous move in TURN
      cyc(0, 1, 0, 0);
      cyc(0, 0, 1, 1);
      cyc(0, 0, 0, 0);
      cyc(0, 1, 1, 2);
      chk_eq("start_vs_move", 32'({board, cur_player, move_ack, move_rej}), 32'd0);

      // clr while evaluating a move
      cyc(0, 0, 1, 4);
      cyc(1, 0, 1, 5);
      chk_eq("clr_in_check", 32'({board, cur_player, move_ack, move_rej, player_win,
                                  player_1_win, player_2_win, draw, game_over}), 32'd0);

      // Move request during evaluation is refused
      cyc(0, 1, 0, 0);
      cyc(0, 0, 1, 1);
      cyc(0, 0, 1, 2);
      chk_eq("busy_rej", 32'(move_rej), 32'd1);
      chk_eq("busy_board", 32'(board), 32'h1);

      // Randomized play
      for (int i = 0; i < 3000; i++) begin
         bit c, s, mv;
         int sq, sp;
         c  = ($urandom_range(0, 999) < 8);
         sp = (m_phase == PhIdle || m_phase == PhDone) ? 30 : 2;
         s  = ($urandom_range(0, 99) < sp);
         mv = ($urandom_range(0, 9) < 7);
         sq = ($urandom_range(0, 9) < 9) ? int'($urandom_range(1, 9)) : int'($urandom_range(0, 15));
         cyc(c, s, mv, sq);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ttt_game_ctrl.md
TTT_GAME_CTRL -- requirements
Module: ttt_game_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port clr, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: request to begin a new game.
REQ-004 SHALL have port move_valid, input, 1 bit: a move request is present this cycle.
REQ-005 SHALL have port move_sq, input, 4 bits: target square 1..9, row-major with 1 at top-left; valid only with move_valid.
REQ-006 SHALL have port board, output, 18 bits: square k status at bits [2k-1:2k-2]; 00 empty, 01 player 1, 10 player 2.
REQ-007 SHALL have port cur_player, output, 1 bit: 0 means player 1 to move, 1 means player 2 to move.
REQ-008 SHALL have port move_ack, output, 1 bit: one-cycle pulse when a move is accepted.
REQ-009 SHALL have port move_rej, output, 1 bit: one-cycle pulse when a move is rejected.
REQ-010 SHALL have ports player_win, player_1_win, player_2_win, draw, game_over, all output, 1 bit each: game result flags.

Function
REQ-011 SHALL implement the FSM states IDLE, TURN, CHECK and DONE.
REQ-012 In IDLE, start SHALL clear the board and the move counter, set cur_player=0, and enter TURN on the next cycle.
REQ-013 In TURN, a move SHALL be accepted when move_valid=1, move_sq is in 1..9 and the target square is 00; otherwise it SHALL be rejected.
REQ-014 On acceptance in cycle N, the following SHALL hold at N+1:
  - square written with cur_player+1 encoding;
  - move counter incremented;
  - move_ack=1;
  - state=CHECK.
REQ-015 On rejection in cycle N:
  - move_rej=1 at N+1;
  - board, cur_player and state unchanged.
REQ-016 In CHECK, the updated board SHALL be evaluated, and at the next cycle:
  - on a win for the mover, state=DONE with player_win=1 and the matching player_x_win=1;
  - with no win and move counter=9, state=DONE with draw=1;
  - otherwise cur_player SHALL toggle and state=TURN.
REQ-017 A win on the ninth move SHALL report a win, never draw; draw and player_win SHALL never both be 1.
REQ-018 game_over SHALL be 1 exactly while in DONE.
REQ-019 The board and all result flags SHALL hold stable in DONE until start or clr.
REQ-020 move_valid in IDLE, CHECK or DONE SHALL produce move_rej at the next cycle, with no state change.
REQ-021 start in TURN, CHECK or DONE SHALL abort or restart the game exactly as in REQ-012.
REQ-022 start SHALL take priority over a simultaneous move_valid; that move SHALL be discarded, with neither ack nor rej.
REQ-023 move_ack and move_rej SHALL be mutually exclusive and never asserted two cycles in a row for a single request.
REQ-024 The move counter SHALL be 4 bits and saturate at 9.
REQ-025 Win detection SHALL test 3 rows, 3 columns and 2 diagonals for all-01 or all-10.

Reset
REQ-026 When clr=1 at a clock edge, the next state SHALL be:
  - state=IDLE;
  - board=0, move counter=0, cur_player=0;
  - all pulse and result outputs=0.
REQ-027 clr SHALL dominate start and move_valid in the same cycle, including mid-game and in CHECK.

Structure
REQ-028 Shared package ttt_pkg SHALL hold:
  - square encodings SQ_EMPTY=00, SQ_P1=01, SQ_P2=10;
  - FSM state encoding;
  - the constant MAX_MOVES=9.
REQ-029 Win evaluation SHALL be a purely combinational sub-module ttt_line_detect: 18-bit board in, p1_line and p2_line out.
REQ-030 All outputs of ttt_game_ctrl SHALL be registered.

Verification
REQ-031 Row win: clr, then start, then accepted moves 1,4,2,5,3 → move_ack after each; two cycles after the move on square 3, player_win=1, player_1_win=1, game_over=1, board=18'h00015 in the row-1 bits.
REQ-032 Occupied or illegal square: move on 5, then a second move on 5 → move_rej=1 with board unchanged and cur_player=1; a move with move_sq=0 or 10 in TURN → move_rej=1.
REQ-033 Draw: the move sequence 1,2,3,5,4,6,8,7,9 → draw=1, player_win=0, game_over=1; a subsequent move_valid → move_rej=1.
REQ-034 Ninth-move win: a sequence in which player 1's fifth move completes a diagonal → player_1_win=1 and draw=0.
REQ-035 Simultaneous events:
  - start together with move_valid in TURN → board=0 next cycle with no ack or rej;
  - clr during CHECK → IDLE, all outputs 0.
REQ-036 Busy rejection: move_valid asserted on the CHECK cycle → move_rej=1 and no second write.
